// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_r_next;

  // Single full-subtractor cell fed by the LSBs of the operand shift registers.
  assign w_x       = r_a_sh[0];
  assign w_y       = r_b_sh[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_r_next  = {w_d, r_sh[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sh     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_sh    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sh   <= w_r_next;
          r_br   <= w_br_next;
          if (w_last) begin
            // Result registers are written only here, so they hold between operations.
            diff     <= w_r_next;
            borrow   <= w_br_next;
            zero     <= (w_r_next == '0);
            overflow <= (r_a_msb != r_b_msb) && (w_r_next[WIDTH-1] != r_a_msb);
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16: directed cases,
// backpressure, mid-operation reset and a random regression against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, diff8;
  logic        borrow8, overflow8, zero8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, diff16;
  logic        borrow16, overflow16, zero16;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cur8   = 1'b1;

  logic [15:0] obs_diff;
  logic        obs_in_ready, obs_out_valid, obs_borrow, obs_overflow, obs_zero;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .borrow(borrow8), .overflow(overflow8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .diff(diff16), .borrow(borrow16), .overflow(overflow16), .zero(zero16)
  );

  assign obs_diff      = cur8 ? {8'h00, diff8} : diff16;
  assign obs_in_ready  = cur8 ? in_ready8  : in_ready16;
  assign obs_out_valid = cur8 ? out_valid8 : out_valid16;
  assign obs_borrow    = cur8 ? borrow8    : borrow16;
  assign obs_overflow  = cur8 ? overflow8  : overflow16;
  assign obs_zero      = cur8 ? zero8      : zero16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] d, output logic br, output logic ov, output logic z);
    int mask, ua, ub, sa, sb, sd;
    mask = (1 << w) - 1;
    ua   = int'(av) & mask;
    ub   = int'(bv) & mask;
    d    = 16'((ua - ub) & mask);
    br   = (ua < ub);
    sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sd   = sa - sb;
    ov   = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
    z    = (d == 16'h0000);
  endtask

  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv, input logic ordy);
    if (cur8) begin
      in_valid8 = v; a8 = av[7:0]; b8 = bv[7:0]; out_ready8 = ordy;
    end else begin
      in_valid16 = v; a16 = av; b16 = bv; out_ready16 = ordy;
    end
  endtask

  // One full transaction starting at a negedge while the DUT is idle.
  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input int bp, input bit junk, input string tag);
    logic [15:0] e_d;
    logic        e_br, e_ov, e_z;
    int          lat;
    model(w, av, bv, e_d, e_br, e_ov, e_z);
    cur8 = (w == 8);
    #1;
    drive(1'b1, av, bv, 1'b0);
    check({tag, "_accept_rdy"}, obs_in_ready, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      drive(junk ? 1'($urandom) : 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      if (lat == 1) check({tag, "_busy_rdy"}, obs_in_ready, 0);
    end while (!obs_out_valid && lat < 4 * w + 8);
    check({tag, "_latency"}, lat, w + 1);
    check({tag, "_diff"}, obs_diff, e_d);
    check({tag, "_borrow"}, obs_borrow, e_br);
    check({tag, "_ovf"}, obs_overflow, e_ov);
    check({tag, "_zero"}, obs_zero, e_z);
    for (int i = 0; i < bp; i++) begin
      drive(junk ? 1'($urandom) : 1'b0, 16'($urandom), 16'($urandom), 1'b0);
      @(negedge clk);
      check({tag, "_bp_valid"}, obs_out_valid, 1);
      check({tag, "_bp_rdy"}, obs_in_ready, 0);
      check({tag, "_bp_diff"}, {obs_diff, obs_borrow, obs_overflow, obs_zero},
            {e_d, e_br, e_ov, e_z});
    end
    drive(1'b0, 16'($urandom), 16'($urandom), 1'b1);
    @(negedge clk);
    check({tag, "_rel_valid"}, obs_out_valid, 0);
    check({tag, "_rel_rdy"}, obs_in_ready, 1);
    check({tag, "_rel_hold"}, {obs_diff, obs_borrow, obs_overflow, obs_zero},
          {e_d, e_br, e_ov, e_z});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst8_rdy", in_ready8, 1);
    check("rst8_valid", out_valid8, 0);
    check("rst8_outs", {diff8, borrow8, overflow8, zero8}, 0);
    check("rst16_rdy", in_ready16, 1);
    check("rst16_valid", out_valid16, 0);
    check("rst16_outs", {diff16, borrow16, overflow16, zero16}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8, 16'h05, 16'h03, 0, 1'b0, "basic");
    check("basic_const", {obs_diff, obs_borrow, obs_overflow, obs_zero}, {16'h0002, 3'b000});
    run_op(8, 16'h03, 16'h05, 0, 1'b0, "under");
    check("under_const", {obs_diff, obs_borrow, obs_overflow, obs_zero}, {16'h00FE, 3'b100});
    run_op(8, 16'h80, 16'h01, 0, 1'b0, "ovf");
    check("ovf_const", {obs_diff, obs_borrow, obs_overflow, obs_zero}, {16'h007F, 3'b010});
    run_op(8, 16'h2A, 16'h2A, 0, 1'b0, "zero");
    check("zero_const", {obs_diff, obs_borrow, obs_overflow, obs_zero}, {16'h0000, 3'b001});
    run_op(8, 16'h55, 16'h11, 5, 1'b1, "bp");
    check("bp_const", obs_diff, 16'h0044);
    run_op(8, 16'h01, 16'h02, 0, 1'b0, "after_bp");

    // Reset three cycles into SHIFT must abort with no partial result.
    cur8 = 1'b1;
    #1;
    drive(1'b1, 16'h00FF, 16'h0001, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rdy", in_ready8, 1);
    check("midrst_valid", out_valid8, 0);
    check("midrst_outs", {diff8, borrow8, overflow8, zero8}, 0);
    repeat (10) @(negedge clk);
    check("midrst_no_result", out_valid8, 0);
    run_op(8, 16'h10, 16'h20, 0, 1'b0, "post_rst");
    check("post_rst_const", {obs_diff, obs_borrow}, {16'h00F0, 1'b1});

    for (int i = 0; i < 1000; i++)
      run_op(8, 16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'($urandom), "rnd8");
    for (int i = 0; i < 1000; i++)
      run_op(16, 16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'($urandom), "rnd16");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
